mfp_ahb_uart_tx: RTL

- Memory-mapped AHB-lite slave: a transmit-only UART with a write FIFO.
- Sits downstream of the AHB bus decoder/mux as a new slave. It is driven by its own HSEL bit, decoded at physical 0x1f600000, and its HRDATA feeds the bus read mux.
- Software pushes bytes into the FIFO, programs the baud divisor, and polls status.
- The block serialises bytes 8N1, LSB first, on one pin.

---
 rtl/mfp_ahb_uart_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/mfp_ahb_uart_tx.sv
// mfp_ahb_uart_tx: AHB-lite transmit-only 8N1 UART with a TX FIFO; regs TXDATA(0) STATUS(1) BAUDDIV(2), outputs HRDATA/UART_TX/TX_IRQ
module mfp_ahb_uart_tx #(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DIV_RST = 16'd868
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [3:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        UART_TX,
    output logic        TX_IRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_d;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp, count, count_d;
    logic full, empty, push, pop, wr_pend, ovf, addr_ph, tx_d, unused_ok;
    logic [1:0] wr_addr;
    logic [15:0] baud, bcnt, bcnt_d, div_m1;
    logic [7:0] shift, shift_d, status;
    logic [2:0] bitn, bitn_d;
    logic [31:0] rdata_nxt;
    assign unused_ok = ^{HADDR[1:0], HWDATA[31:16]};
    assign addr_ph = HSEL && HTRANS[1];
    assign count = wp - rp;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign empty = wp == rp;
    assign push = wr_pend && wr_addr == 2'd0 && !full;
    assign count_d = (wp + (AW+1)'(push)) - (rp + (AW+1)'(pop));
    assign div_m1 = (baud == 16'd0) ? 16'd0 : baud - 16'd1;
    assign status = {4'(count), ovf, empty, full, state != IDLE};
    assign rdata_nxt = (HADDR[3:2] == 2'd1) ? {24'b0, status} :
                       (HADDR[3:2] == 2'd2) ? {16'b0, baud} : 32'b0;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend <= 1'b0;
            wr_addr <= 2'd0;
            HRDATA  <= 32'b0;
            baud    <= BAUD_DIV_RST;
            ovf     <= 1'b0;
            wp      <= '0;
        end else begin
            wr_pend <= addr_ph && HWRITE;
            if (addr_ph) wr_addr <= HADDR[3:2];
            if (addr_ph && !HWRITE) HRDATA <= rdata_nxt;
            if (wr_pend && wr_addr == 2'd2) baud <= HWDATA[15:0];
            if (wr_pend && wr_addr == 2'd0 && full) ovf <= 1'b1;
            else if (wr_pend && wr_addr == 2'd1 && HWDATA[3]) ovf <= 1'b0;
            if (push) wp <= wp + 1'b1;
        end
    end
    always_ff @(posedge HCLK) begin
        if (push) mem[wp[AW-1:0]] <= HWDATA[7:0];
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= IDLE;
            rp      <= '0;
            bcnt    <= 16'd0;
            shift   <= 8'd0;
            bitn    <= 3'd0;
            UART_TX <= 1'b1;
            TX_IRQ  <= 1'b1;
        end else begin
            state   <= state_d;
            rp      <= rp + (AW+1)'(pop);
            bcnt    <= bcnt_d;
            shift   <= shift_d;
            bitn    <= bitn_d;
            UART_TX <= tx_d;
            TX_IRQ  <= count_d == '0 && state_d == IDLE;
        end
    end
    always_comb begin
        state_d = state;
        shift_d = shift;
        bitn_d  = bitn;
        bcnt_d  = (bcnt == 16'd0) ? div_m1 : bcnt - 16'd1;
        pop     = 1'b0;
        tx_d    = 1'b1;
        unique case (state)
            IDLE: begin
                bcnt_d = div_m1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rp[AW-1:0]];
                    bitn_d  = 3'd0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                state_d = (bcnt == 16'd0) ? DATA : START;
                tx_d    = (bcnt == 16'd0) ? shift[0] : 1'b0;
            end
            DATA: begin
                tx_d = shift[0];
                if (bcnt == 16'd0) begin
                    state_d = (bitn == 3'd7) ? STOP : DATA;
                    shift_d = shift >> 1;
                    bitn_d  = bitn + 3'd1;
                    tx_d    = (bitn == 3'd7) ? 1'b1 : shift[1];
                end
            end
            STOP: state_d = (bcnt == 16'd0) ? IDLE : STOP;
        endcase
    end
endmodule
